// File: rtl/instruction_fetch_unit.sv
// PC generator and fetch queue sitting between the instruction memory and
// decode. The PC drives the memory address directly; the returned word is
// captured together with its PC into a small circular FIFO whose head is
// offered to decode over a valid/ready handshake. Redirects flush the FIFO
// and reload the PC; a misaligned redirect target parks the unit in FAULT
// until an aligned redirect arrives.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_VECTOR = 64'h0,
  parameter int          DEPTH        = 2
) (
  input  logic        clk,
  input  logic        resetN,
  output logic [63:0] imemAddress,
  input  logic [31:0] imemInstruction,
  input  logic        redirectValid,
  input  logic [63:0] redirectTarget,
  output logic        fetchValid,
  output logic [31:0] fetchInstruction,
  output logic [63:0] fetchPc,
  input  logic        fetchReady,
  output logic        fetchFault,
  output logic [63:0] faultPc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FAULT = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [63:0]        pc_p0;
  logic [63:0]        q_pc_p1   [DEPTH];
  logic [31:0]        q_insn_p1 [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;
  logic               fault_q;
  logic [63:0]        fault_pc_q;

  logic               push;
  logic               pop;
  logic               target_aligned;

  // Sequential PC advance; wraps modulo 2^64 by natural overflow.
  function automatic logic [63:0] pc_inc(input logic [63:0] p);
    return p + 64'd4;
  endfunction

  // Circular pointer advance; DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_C) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign target_aligned = (redirectTarget[1:0] == 2'b00);

  // Head is only exposed while running; FAULT is entered through a flush so
  // count is zero there anyway, the state term just makes it explicit.
  assign fetchValid = (state == S_RUN) && (count != '0);
  assign pop        = fetchValid && fetchReady;
  assign push       = (state == S_RUN) && !redirectValid && ((count < DEPTH_C) || pop);

  // ---- stage p0: PC register drives the memory address ----
  assign imemAddress = pc_p0;

  // ---- stage p1: queue head feeds decode, no path from imemInstruction ----
  assign fetchPc          = q_pc_p1[head];
  assign fetchInstruction = q_insn_p1[head];
  assign fetchFault       = fault_q;
  assign faultPc          = fault_pc_q;

  // Next-state logic: only a redirect moves the FSM, alignment picks the state.
  always_comb begin
    state_nxt = state;
    if (redirectValid) begin
      state_nxt = target_aligned ? S_RUN : S_FAULT;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state <= S_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // PC, queue pointers/occupancy and fault capture; redirect beats push/pop.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      pc_p0      <= RESET_VECTOR;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else if (redirectValid) begin
      pc_p0 <= redirectTarget;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      if (target_aligned) begin
        fault_q <= 1'b0;
      end else begin
        fault_q    <= 1'b1;
        fault_pc_q <= redirectTarget;
      end
    end else begin
      if (push) begin
        pc_p0 <= pc_inc(pc_p0);
        tail  <= ptr_inc(tail);
      end
      if (pop) begin
        head <= ptr_inc(head);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Queue storage: capture {pc, instruction} at the tail on every push.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_pc_p1[i]   <= '0;
        q_insn_p1[i] <= '0;
      end
    end else if (push) begin
      q_pc_p1[tail]   <= pc_p0;
      q_insn_p1[tail] <= imemInstruction;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a scoreboard of expected {pc, insn}
// pairs is loaded whenever a fetch stream is started (reset release or
// redirect) and consumed on every accepted handshake; directed checks cover
// reset, latency, back-pressure, flush, fault and PC wrap.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT, RESET_VECTOR = 0
  logic        resetN;
  logic [63:0] imemAddress;
  logic [31:0] imemInstruction;
  logic        redirectValid;
  logic [63:0] redirectTarget;
  logic        fetchValid;
  logic [31:0] fetchInstruction;
  logic [63:0] fetchPc;
  logic        fetchReady;
  logic        fetchFault;
  logic [63:0] faultPc;

  // wrap DUT, RESET_VECTOR at top of the address space
  logic        resetN_w;
  logic [63:0] imemAddress_w;
  logic [31:0] imemInstruction_w;
  logic        redirectValid_w;
  logic [63:0] redirectTarget_w;
  logic        fetchValid_w;
  logic [31:0] fetchInstruction_w;
  logic [63:0] fetchPc_w;
  logic        fetchReady_w;
  logic        fetchFault_w;
  logic [63:0] faultPc_w;

  localparam logic [63:0] WRAP_VEC = 64'hFFFF_FFFF_FFFF_FFFC;

  instruction_fetch_unit #(.RESET_VECTOR(64'h0), .DEPTH(2)) u_dut (
    .clk              (clk),
    .resetN           (resetN),
    .imemAddress      (imemAddress),
    .imemInstruction  (imemInstruction),
    .redirectValid    (redirectValid),
    .redirectTarget   (redirectTarget),
    .fetchValid       (fetchValid),
    .fetchInstruction (fetchInstruction),
    .fetchPc          (fetchPc),
    .fetchReady       (fetchReady),
    .fetchFault       (fetchFault),
    .faultPc          (faultPc)
  );

  instruction_fetch_unit #(.RESET_VECTOR(WRAP_VEC), .DEPTH(2)) u_wrap (
    .clk              (clk),
    .resetN           (resetN_w),
    .imemAddress      (imemAddress_w),
    .imemInstruction  (imemInstruction_w),
    .redirectValid    (redirectValid_w),
    .redirectTarget   (redirectTarget_w),
    .fetchValid       (fetchValid_w),
    .fetchInstruction (fetchInstruction_w),
    .fetchPc          (fetchPc_w),
    .fetchReady       (fetchReady_w),
    .fetchFault       (fetchFault_w),
    .faultPc          (faultPc_w)
  );

  // memory word k (address 4k) holds 0x1000 + k
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [63:0] w;
    w = a >> 2;
    return 32'h1000 + w[31:0];
  endfunction

  always_comb imemInstruction   = mem_word(imemAddress);
  always_comb imemInstruction_w = mem_word(imemAddress_w);

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] insn;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_pops   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // expected stream after a restart at 'start'
  task automatic sb_load(input logic [63:0] start);
    sb.delete();
    for (int i = 0; i < 64; i++) begin
      sb.push_back('{pc: start + 64'(4 * i), insn: mem_word(start + 64'(4 * i))});
    end
  endtask

  // Inputs are already set; score the handshake about to happen, then advance.
  task automatic cycle();
    exp_t e;
    if (resetN && !redirectValid && fetchValid && fetchReady) begin
      check_eq("sb_avail", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_pops++;
        check_eq("sb_pc", fetchPc, e.pc);
        check_eq("sb_insn", 64'(fetchInstruction), 64'(e.insn));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [63:0] tgt);
    redirectValid  = 1'b1;
    redirectTarget = tgt;
    cycle();
    redirectValid  = 1'b0;
  endtask

  initial begin
    resetN           = 1'b0;
    redirectValid    = 1'b0;
    redirectTarget   = '0;
    fetchReady       = 1'b0;
    resetN_w         = 1'b0;
    redirectValid_w  = 1'b0;
    redirectTarget_w = '0;
    fetchReady_w     = 1'b0;

    cycle();
    cycle();
    check_eq("rst_valid", 64'(fetchValid), 64'd0);
    check_eq("rst_fault", 64'(fetchFault), 64'd0);
    check_eq("rst_faultpc", faultPc, 64'd0);
    check_eq("rst_addr", imemAddress, 64'd0);
    check_eq("rst_addr_wrap", imemAddress_w, WRAP_VEC);

    // 1: streaming from reset, one per cycle
    sb_load(64'h0);
    resetN     = 1'b1;
    fetchReady = 1'b1;
    cycle();
    check_eq("t1_valid", 64'(fetchValid), 64'd1);
    check_eq("t1_pc0", fetchPc, 64'h0);
    check_eq("t1_insn0", 64'(fetchInstruction), 64'h1000);
    check_eq("t1_addr", imemAddress, 64'h4);
    n_pops = 0;
    for (int i = 0; i < 5; i++) cycle();
    check_eq("t1_pops", 64'(n_pops), 64'd5);
    check_eq("t1_addr_end", imemAddress, 64'd24);

    // 2: back-pressure fills the queue and stalls the PC
    fetchReady = 1'b0;
    sb_load(64'h0);
    redirect(64'h0);
    cycle();
    check_eq("t2_first_pc", fetchPc, 64'h0);
    for (int i = 0; i < 5; i++) cycle();
    check_eq("t2_valid", 64'(fetchValid), 64'd1);
    check_eq("t2_addr_stall", imemAddress, 64'h8);
    check_eq("t2_head_pc", fetchPc, 64'h0);
    fetchReady = 1'b1;
    n_pops = 0;
    for (int i = 0; i < 6; i++) cycle();
    check_eq("t2_pops", 64'(n_pops), 64'd6);

    // 3: redirect with a full queue and a concurrent handshake
    fetchReady = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    fetchReady = 1'b1;
    sb_load(64'h100);
    redirect(64'h100);
    check_eq("t3_valid_flush", 64'(fetchValid), 64'd0);
    check_eq("t3_addr", imemAddress, 64'h100);
    cycle();
    check_eq("t3_pc", fetchPc, 64'h100);
    n_pops = 0;
    for (int i = 0; i < 4; i++) cycle();
    check_eq("t3_pops", 64'(n_pops), 64'd4);

    // 4: misaligned redirect faults, aligned redirect recovers
    sb.delete();
    redirect(64'h102);
    check_eq("t4_fault", 64'(fetchFault), 64'd1);
    check_eq("t4_faultpc", faultPc, 64'h102);
    check_eq("t4_addr", imemAddress, 64'h102);
    for (int i = 0; i < 11; i++) begin
      check_eq("t4_valid_held", 64'(fetchValid), 64'd0);
      check_eq("t4_addr_held", imemAddress, 64'h102);
      cycle();
    end
    check_eq("t4_fault_held", 64'(fetchFault), 64'd1);
    sb_load(64'h200);
    redirect(64'h200);
    check_eq("t4_fault_clr", 64'(fetchFault), 64'd0);
    check_eq("t4_valid_gap", 64'(fetchValid), 64'd0);
    cycle();
    check_eq("t4_valid", 64'(fetchValid), 64'd1);
    check_eq("t4_pc", fetchPc, 64'h200);
    n_pops = 0;
    for (int i = 0; i < 3; i++) cycle();
    check_eq("t4_pops", 64'(n_pops), 64'd3);

    // 6: mid-operation reset with a full queue
    fetchReady = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    check_eq("t6_full_valid", 64'(fetchValid), 64'd1);
    resetN = 1'b0;
    cycle();
    check_eq("t6_valid", 64'(fetchValid), 64'd0);
    check_eq("t6_addr", imemAddress, 64'h0);
    check_eq("t6_fault", 64'(fetchFault), 64'd0);
    sb_load(64'h0);
    resetN     = 1'b1;
    fetchReady = 1'b1;
    cycle();
    check_eq("t6_restart_pc", fetchPc, 64'h0);
    n_pops = 0;
    for (int i = 0; i < 4; i++) cycle();
    check_eq("t6_pops", 64'(n_pops), 64'd4);

    // 5: PC wrap at the top of the address space
    resetN_w     = 1'b1;
    fetchReady_w = 1'b1;
    cycle();
    check_eq("t5_valid", 64'(fetchValid_w), 64'd1);
    check_eq("t5_pc0", fetchPc_w, WRAP_VEC);
    check_eq("t5_insn0", 64'(fetchInstruction_w), 64'(mem_word(WRAP_VEC)));
    check_eq("t5_addr", imemAddress_w, 64'h0);
    cycle();
    check_eq("t5_pc1", fetchPc_w, 64'h0);
    check_eq("t5_insn1", 64'(fetchInstruction_w), 64'h1000);
    cycle();
    check_eq("t5_pc2", fetchPc_w, 64'h4);
    check_eq("t5_insn2", 64'(fetchInstruction_w), 64'h1001);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
PC-generation and fetch-buffer stage directly upstream of the hard instruction memory and downstream-feeding the decode stage. Drives the memory address from its PC register and samples the returned combinational instruction word into a small FIFO of {pc, instruction} pairs. Presents those pairs to decode over a valid/ready handshake. Handles control-flow redirects and flushes, and traps misaligned redirect targets.

Parameters:
RESET_VECTOR, 64'h0, PC loaded on reset; must be 4-byte aligned.
DEPTH, 2, fetch queue entries; legal range 2..8.

Ports:
clk  in  1  single clock, rising edge
resetN  in  1  reset; synchronous, active-low
imemAddress  out  64  byte address to instruction memory; always equals the PC register
imemInstruction  in  32  instruction word from memory, combinational from imemAddress
redirectValid  in  1  load redirectTarget into PC and flush queue this cycle
redirectTarget  in  64  new PC
fetchValid  out  1  queue head valid
fetchInstruction  out  32  queue head instruction
fetchPc  out  64  queue head PC
fetchReady  in  1  decode accepts head when fetchValid && fetchReady
fetchFault  out  1  misaligned-redirect fault held
faultPc  out  64  offending target; valid while fetchFault=1

Behaviour:
- Reset (resetN=0 at clk edge): pc=RESET_VECTOR, queue count=0, state=RUN, fetchValid=0, fetchFault=0, faultPc=0. fetchInstruction/fetchPc are don't-care while fetchValid=0. A mid-operation reset discards all queued entries.
- Queue: DEPTH-entry circular FIFO of registered {pc, instruction}.
  - Outputs come from the head register; no combinational path from imemInstruction to fetch* outputs.
  - Pop = fetchValid && fetchReady.
  - Push = (state==RUN) && !redirectValid && (count<DEPTH || pop).
  - Simultaneous push and pop with count==DEPTH is legal; count is unchanged.
- On push: entry={pc, imemInstruction}; pc<=pc+4, modulo 2^64 (0xFFFF_FFFF_FFFF_FFFC wraps to 0).
- Without a push, pc holds.
- Latency: the PC presented in cycle N appears at fetchPc in cycle N+1 if the queue was empty. Sustained throughput is 1 instruction/cycle with fetchReady=1.
- Redirect (highest priority, overrides push and pop):
  - Queue cleared (count<=0); fetchValid=0 next cycle.
  - A head handshaked in the same cycle is discarded; decode must treat redirect as a kill.
  - pc<=redirectTarget.
  - If redirectTarget[1:0]==0: state<=RUN, fetchFault<=0.
  - Else: state<=FAULT, fetchFault<=1, faultPc<=redirectTarget.
- State machine:
  - RUN: normal fetch as above.
  - FAULT: no pushes; fetchValid=0; imemAddress still equals pc (the misaligned target). Exits only via a redirect with an aligned target, which returns to RUN on the next cycle.
- Back-to-back redirects: the last one wins; each one flushes.
- fetchReady while fetchValid=0 has no effect.
- No X propagation: all state registers are reset.

Test Plan:
1. Release reset with RESET_VECTOR=0, fetchReady=1, memory word k = 0x1000+k -> imemAddress 0,4,8,… one per cycle; fetchPc=0 with fetchInstruction=0x1000 on the first cycle after reset, then 4/0x1001, 8/0x1002 on consecutive cycles.
2. Hold fetchReady=0 for 5 cycles after the first valid -> count reaches 2, imemAddress stalls at 8, fetchPc stays 0. Raise fetchReady -> sequence 0,4,8,12 with no loss or duplicate.
3. Queue full, fetchReady=1, redirectValid=1 with target 0x100 -> next cycle fetchValid=0 and imemAddress=0x100; the cycle after, fetchPc=0x100. PCs 4 and 8 are never presented.
4. Redirect target 0x102 -> fetchFault=1, faultPc=0x102, fetchValid=0 for 10+ cycles. Redirect to 0x200 -> fetchFault=0 and fetchPc=0x200 two cycles later.
5. RESET_VECTOR=64'hFFFF_FFFF_FFFF_FFFC, fetchReady=1 -> fetchPc sequence FFFF_FFFF_FFFF_FFFC, then 0, then 4.
6. Queue full, assert resetN=0 for 1 cycle -> fetchValid=0, imemAddress=RESET_VECTOR, fetchFault=0. Fetching restarts from RESET_VECTOR on release.
